data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder.sv | 96 +++++++++
 tb/tb_data_memory_responder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: enable/busy handshake responder for a byte-maskable 64-bit word memory.
module data_memory_responder #(
    parameter int    ADDR_WIDTH = 12,
    parameter int    LATENCY    = 3,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [63:0]           write_data,
    input  logic [7:0]            byte_write_enable,
    output logic [63:0]           read_data,
    output logic                  busy
);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int WW = ADDR_WIDTH - 3;

    if (LATENCY < 1 || LATENCY > 255) begin : g_latency_check
        $error("data_memory_responder: LATENCY must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [WW-1:0] word, word_n;
    logic [63:0]   data, data_n, read_data_n, merged;
    logic [7:0]    mask, mask_n;
    logic          busy_n, commit;
    logic [63:0]   mem [2**WW];
    logic          unused_bits;

    assign unused_bits = ^address[2:0];

    always_comb begin
        merged = mem[word];
        for (int i = 0; i < 8; i++)
            if (mask[i]) merged[8*i +: 8] = data[8*i +: 8];
    end

    assign commit = state == ACCESS && count == CW'(1);

    always_comb begin
        state_n     = state;
        count_n     = count;
        word_n      = word;
        data_n      = data;
        mask_n      = mask;
        busy_n      = busy;
        read_data_n = read_data;
        case (state)
            IDLE: if (enable) begin
                state_n = ACCESS;
                count_n = CW'(LATENCY);
                word_n  = address[ADDR_WIDTH-1:3];
                data_n  = write_data;
                mask_n  = byte_write_enable;
                busy_n  = 1'b1;
            end
            ACCESS: begin
                count_n = count - CW'(1);
                if (commit) begin
                    state_n     = RELEASE;
                    busy_n      = 1'b0;
                    read_data_n = merged;
                end
            end
            RELEASE: if (!enable) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            word      <= '0;
            data      <= '0;
            mask      <= '0;
            busy      <= 1'b0;
            read_data <= '0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            word      <= word_n;
            data      <= data_n;
            mask      <= mask_n;
            busy      <= busy_n;
            read_data <= read_data_n;
        end
    end

    always_ff @(posedge clock)
        if (commit) mem[word] <= merged;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed checks of the data-port (LATENCY=3) and fetch-port (LATENCY=1) responders.
module tb_data_memory_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en_d = 1'b0, en_i = 1'b0;
    logic [11:0] addr_d = '0, addr_i = '0;
    logic [63:0] wd_d = '0, wd_i = '0;
    logic [7:0]  be_d = '0, be_i = '0;
    logic [63:0] rd_d, rd_i;
    logic        busy_d, busy_i;
    int          checks = 0;
    int          fails = 0;
    int          bc;

    always #5 clock = ~clock;

    data_memory_responder #(.ADDR_WIDTH(12), .LATENCY(3)) dut_d (
        .clock(clock), .reset(reset), .enable(en_d), .address(addr_d),
        .write_data(wd_d), .byte_write_enable(be_d), .read_data(rd_d), .busy(busy_d));

    data_memory_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut_i (
        .clock(clock), .reset(reset), .enable(en_i), .address(addr_i),
        .write_data(wd_i), .byte_write_enable(be_i), .read_data(rd_i), .busy(busy_i));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One data-port access; hold keeps enable up that many cycles after busy falls.
    task automatic access_d(input logic [11:0] a, input logic [63:0] wd, input logic [7:0] m,
                            input int hold, input string tag, input logic [63:0] exp);
        int n;
        int hi;
        n = 0;
        hi = 0;
        addr_d = a; wd_d = wd; be_d = m; en_d = 1'b1;
        @(negedge clock);
        while (busy_d && n < 20) begin
            n++;
            @(negedge clock);
        end
        check({tag, " busy cycles"}, 64'(n), 64'd3);
        check({tag, " read_data"}, rd_d, exp);
        if (hold > 0) begin
            wd_d = ~wd;
            repeat (hold) begin
                @(negedge clock);
                if (busy_d) hi++;
            end
            check({tag, " no retrigger"}, 64'(hi), 64'd0);
        end
        en_d = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("async reset busy", {63'd0, busy_d}, 64'd0);
        check("async reset read_data", rd_d, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle busy", {63'd0, busy_d}, 64'd0);

        access_d(12'd16, 64'h0123456789ABCDEF, 8'hFF, 0, "init write", 64'h0123456789ABCDEF);
        access_d(12'd16, 64'h0, 8'h00, 0, "read word2", 64'h0123456789ABCDEF);
        access_d(12'd16, 64'hFFFF_FFFF_FFFF_FFAA, 8'h01, 0, "mask 01", 64'h0123456789ABCDAA);
        access_d(12'd16, 64'h11223344, 8'h0F, 0, "mask 0F", 64'h0123456711223344);
        access_d(12'd20, 64'h0, 8'h00, 0, "read addr20", 64'h0123456711223344);

        access_d(12'd24, 64'hA5A5_0000_1111_2222, 8'hFF, 10, "held", 64'hA5A5_0000_1111_2222);
        access_d(12'd24, 64'h0, 8'h00, 0, "held readback", 64'hA5A5_0000_1111_2222);

        access_d(12'd32, 64'h4444_4444_4444_4444, 8'hFF, 0, "word4 init", 64'h4444_4444_4444_4444);
        access_d(12'd40, 64'h5555_5555_5555_5555, 8'hFF, 0, "word5 init", 64'h5555_5555_5555_5555);
        addr_d = 12'd32; wd_d = 64'hCAFE_F00D_CAFE_F00D; be_d = 8'hFF; en_d = 1'b1;
        @(negedge clock);
        @(negedge clock);
        addr_d = 12'd40; wd_d = 64'hDEAD_BEEF_DEAD_BEEF;
        bc = 0;
        while (busy_d && bc < 20) begin
            bc++;
            @(negedge clock);
        end
        check("midchange busy fall", {63'd0, busy_d}, 64'd0);
        check("midchange read_data", rd_d, 64'hCAFE_F00D_CAFE_F00D);
        en_d = 1'b0;
        @(negedge clock);
        access_d(12'd32, 64'h0, 8'h00, 0, "midchange word4", 64'hCAFE_F00D_CAFE_F00D);
        access_d(12'd40, 64'h0, 8'h00, 0, "midchange word5", 64'h5555_5555_5555_5555);

        access_d(12'd48, 64'h6666_6666_6666_6666, 8'hFF, 0, "word6 init", 64'h6666_6666_6666_6666);
        addr_d = 12'd48; wd_d = 64'h7777_7777_7777_7777; be_d = 8'hFF; en_d = 1'b1;
        @(negedge clock);
        check("abort busy before", {63'd0, busy_d}, 64'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort busy", {63'd0, busy_d}, 64'd0);
        check("abort read_data", rd_d, 64'd0);
        en_d = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        access_d(12'd48, 64'h0, 8'h00, 0, "abort no write", 64'h6666_6666_6666_6666);

        addr_i = 12'd8; wd_i = 64'h0000_ABCD_1234_5678; be_i = 8'hFF; en_i = 1'b1;
        @(negedge clock);
        check("fetch1 busy", {63'd0, busy_i}, 64'd1);
        @(negedge clock);
        check("fetch1 done", {63'd0, busy_i}, 64'd0);
        check("fetch1 read_data", rd_i, 64'h0000_ABCD_1234_5678);
        en_i = 1'b0;
        @(negedge clock);
        check("fetch gap busy", {63'd0, busy_i}, 64'd0);
        be_i = 8'h00; en_i = 1'b1;
        @(negedge clock);
        check("fetch2 accepted E0+3", {63'd0, busy_i}, 64'd1);
        @(negedge clock);
        check("fetch2 done", {63'd0, busy_i}, 64'd0);
        check("fetch2 read_data", rd_i, 64'h0000_ABCD_1234_5678);
        en_i = 1'b0;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
